// File: rtl/io_input_conditioner_if.sv
// Switch-input bundle: raw asynchronous switch levels in, conditioned port words and change strobe out.
interface io_input_conditioner_if #(
    parameter int SW_W = 10
);
    logic [SW_W-1:0] sw_raw;
    logic [31:0]     in_port0;
    logic [31:0]     in_port1;
    logic            changed;

    modport master (output sw_raw, input in_port0, in_port1, changed);
    modport slave  (input sw_raw, output in_port0, in_port1, changed);
endinterface

// File: rtl/io_input_conditioner.sv
// Board-switch front end: 2-flop synchronizer, tick-sampled per-bit debouncer,
// and a split into two zero-extended 32-bit input-port words with a change strobe.
module io_input_conditioner #(
    parameter int SW_W    = 10,
    parameter int FIELD_W = 5,
    parameter int DIV     = 50000,
    parameter int STABLE  = 4
) (
    input  logic                   io_clk,
    input  logic                   reset,
    io_input_conditioner_if.slave  bus
);
    localparam int CTR_W = (STABLE > 1) ? $clog2(STABLE) : 1;
    localparam int PS_W  = (DIV > 1) ? $clog2(DIV) : 1;

    generate
        if (FIELD_W > 32 || (SW_W - FIELD_W) > 32 || SW_W <= FIELD_W || FIELD_W < 1 ||
            DIV < 1 || STABLE < 1) begin : g_bad_params
            $error("io_input_conditioner: illegal parameter combination");
        end
    endgenerate

    logic [SW_W-1:0]  sync1;
    logic [SW_W-1:0]  sync2;
    logic [SW_W-1:0]  db;
    logic [SW_W-1:0]  db_next;
    logic [CTR_W-1:0] ctr      [SW_W];
    logic [CTR_W-1:0] ctr_next [SW_W];
    logic [PS_W-1:0]  cnt;
    logic             tick;
    logic             changed_r;

    assign tick = (cnt == PS_W'(DIV - 1));

    always_ff @(posedge io_clk) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            db        <= '0;
            cnt       <= '0;
            changed_r <= 1'b0;
            for (int i = 0; i < SW_W; i++) ctr[i] <= '0;
        end else begin
            sync1     <= bus.sw_raw;
            sync2     <= sync1;
            cnt       <= tick ? '0 : cnt + PS_W'(1);
            db        <= db_next;
            changed_r <= (db_next != db);
            for (int i = 0; i < SW_W; i++) ctr[i] <= ctr_next[i];
        end
    end

    // A bit flips only after STABLE consecutive differing samples; any agreeing sample restarts it.
    always_comb begin
        db_next = db;
        for (int i = 0; i < SW_W; i++) ctr_next[i] = ctr[i];
        if (tick) begin
            for (int i = 0; i < SW_W; i++) begin
                if (sync2[i] == db[i]) begin
                    ctr_next[i] = '0;
                end else if (ctr[i] == CTR_W'(STABLE - 1)) begin
                    db_next[i]  = ~db[i];
                    ctr_next[i] = '0;
                end else begin
                    ctr_next[i] = ctr[i] + CTR_W'(1);
                end
            end
        end
    end

    assign bus.in_port0 = 32'(db[FIELD_W-1:0]);
    assign bus.in_port1 = 32'(db[SW_W-1:FIELD_W]);
    assign bus.changed  = changed_r;
endmodule

// File: doc/io_input_conditioner.md
Name: io_input_conditioner

Overview:
Upstream front end for the memory-mapped input ports. It takes raw, asynchronous board switches and runs each bit through a 2-flop synchronizer and a tick-sampled debouncer. The debounced value is split into two zero-extended 32-bit words that drive in_port0 and in_port1 of the I/O input stage. A one-cycle strobe reports any change in the debounced value.

Parameters:
SW_W, 10, number of raw switch inputs
FIELD_W, 5, low field width; sw[FIELD_W-1:0] goes to in_port0, sw[SW_W-1:FIELD_W] goes to in_port1
DIV, 50000, sample-tick period in io_clk cycles (>=1)
STABLE, 4, consecutive differing samples required before a debounced bit flips (>=1)

Ports:
io_clk  input  1  sole clock, rising edge
reset  input  1  synchronous, active-high reset
sw_raw  input  SW_W  raw asynchronous switch levels
in_port0  output  32  {zeros, db[FIELD_W-1:0]}
in_port1  output  32  {zeros, db[SW_W-1:FIELD_W]}
changed  output  1  one-cycle pulse when any debounced bit flips

Behaviour:
- Interface (already decided): one clock, io_clk. Reset is synchronous and active-high on port reset.
- Reset (sampled on an io_clk edge with reset=1):
  - sync stages, debounced register db, per-bit counters, prescaler and changed all clear to 0.
  - in_port0 = in_port1 = 32'h0.
  - Reset has priority over every other update in that cycle.
- Synchronizer: sync1 <= sw_raw; sync2 <= sync1. Only sync2 feeds the debouncer.
- Prescaler:
  - cnt counts 0..DIV-1 and wraps to 0.
  - tick = (cnt == DIV-1), combinational.
  - DIV=1 gives tick=1 every cycle.
  - After reset release, the first tick edge is the DIV-th edge.
- Per-bit debounce, evaluated only on edges where tick=1:
  - sync2[i] == db[i]: ctr[i] <= 0.
  - sync2[i] != db[i] and ctr[i] == STABLE-1: db[i] <= ~db[i]; ctr[i] <= 0.
  - sync2[i] != db[i] otherwise: ctr[i] <= ctr[i]+1.
  - Edges without tick: db and ctr hold.
  - Counter width is clog2(STABLE), minimum 1 bit. STABLE=1 flips on the first differing sample.
- Outputs:
  - in_port0 and in_port1 are wired directly from register db, zero-extended. No added latency.
  - Both ports always update on the same edge.
- changed:
  - Registered. Set to 1 on the edge where any db bit flips; cleared on the next edge unless another flip occurs.
  - Simultaneous flips in several bits or both fields produce a single pulse.
- Latency from a raw change held stable: 2 cycles of synchronization, then STABLE ticks. Worst case is 2 + STABLE*DIV cycles.
- Glitch rejection: a disturbance seen by fewer than STABLE consecutive samples never reaches db. Any agreeing sample zeroes that bit's counter.
- Reset mid-count discards all partial progress. A held input must re-qualify with the full latency.
- Elaboration constraints: FIELD_W <= 32 and SW_W-FIELD_W <= 32 (enforce with an elaboration check). SW_W > FIELD_W.

Test Plan:
(DIV=4, STABLE=3, SW_W=10, FIELD_W=5; reset released before edge 1; sample edges are 4, 8, 12, ...)
1. Reset held 5 cycles with sw_raw=10'h3FF -> in_port0=0, in_port1=0, changed=0 throughout. No flip can occur before edge 12 after release.
2. sw_raw=10'h3A5 applied before edge 1 and held:
   - in_port0=0 and in_port1=0 until edge 12.
   - After edge 12: in_port0=32'h5, in_port1=32'h1D, changed=1 for exactly cycle 12->13.
3. From settled 10'h000, bit0 raised for 6 cycles then dropped (at most 2 samples) -> in_port0 stays 0, changed never asserts. Then held high -> in_port0=32'h1 after the 3rd consecutive high sample.
4. From settled 10'h3A5, sw_raw held for 200 cycles -> no further changed pulses, outputs constant.
5. Raw 10'h01F applied; reset pulsed for 1 cycle after 2 differing samples -> outputs 0 immediately. in_port0=32'h1F appears only after 3 fresh samples, i.e. at the 3rd tick edge after release.
6. From settled 0, sw_raw switched to 10'h021 in one cycle -> in_port0=32'h1 and in_port1=32'h1 update on the same edge, with a single one-cycle changed pulse.
